// File: rtl/alarm_set_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_set_ctrl
//   Button-driven controller for setting the current time and the alarm time
//   of a 24h clock, plus alarm enable, stop and snooze handling.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   btn_mode              : rising edge advances the edit sequence
//   btn_inc               : rising edge increments the field being edited
//   btn_snooze / btn_stop : rising edge requests snooze / alarm stop
//   btn_al_en             : rising edge toggles alarm enable (IDLE only)
//   Alarm                 : ringing indication from the clock block
//   H_in1,H_in0,M_in1,M_in0 : BCD hh:mm towards the clock block
//   LD_time / LD_alarm    : one-cycle load strobes (LOAD_T / LOAD_A states)
//   STOP_al               : one-cycle alarm-stop strobe
//   AL_ON                 : alarm enable level
//   mode                  : current FSM state code
// ---------------------------------------------------------------------------
module alarm_set_ctrl #(
    parameter int SNOOZE_MIN = 5,   // 1..9
    parameter int MAX_SNOOZE = 3    // 1..7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    input  logic       btn_al_en,
    input  logic       Alarm,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        LOAD_T = 3'd3,
        SET_AH = 3'd4,
        SET_AM = 3'd5,
        LOAD_A = 3'd6
    } state_t;

    state_t      state_q, state_d;

    // Hours and minutes are held in binary; BCD is produced only at the output.
    logic [4:0]  t_hr_q, a_hr_q;
    logic [5:0]  t_min_q, a_min_q;
    logic [2:0]  snz_cnt_q;
    logic        stop_q;
    logic        al_on_q;

    // Button edge detection: {mode, inc, snooze, stop, al_en}
    logic [4:0]  btn_now, btn_q, btn_edge;
    logic        e_mode, e_inc, e_snz, e_stop, e_al_en;

    assign btn_now  = {btn_mode, btn_inc, btn_snooze, btn_stop, btn_al_en};
    assign btn_edge = btn_now & ~btn_q;
    assign {e_mode, e_inc, e_snz, e_stop, e_al_en} = btn_edge;

    // Snooze is honoured only in IDLE while ringing; stop and mode edges win.
    // Once the snooze budget is spent, a snooze behaves as a stop.
    logic snooze_ok, snooze_go, snooze_stop, inc_en;
    assign snooze_ok   = (state_q == IDLE) && e_snz && Alarm && !e_stop && !e_mode;
    assign snooze_go   = snooze_ok && (snz_cnt_q < 3'(MAX_SNOOZE));
    assign snooze_stop = snooze_ok && !snooze_go;
    assign inc_en      = e_inc && !e_mode;

    // Alarm time advanced by SNOOZE_MIN with carry into hours (23 -> 00).
    logic [6:0] snz_min_sum;
    logic [5:0] snz_min;
    logic [4:0] snz_hr;
    always_comb begin
        snz_min_sum = {1'b0, a_min_q} + 7'(SNOOZE_MIN);
        snz_min     = 6'(snz_min_sum);
        snz_hr      = a_hr_q;
        if (snz_min_sum >= 7'd60) begin
            snz_min = 6'(snz_min_sum - 7'd60);
            snz_hr  = (a_hr_q == 5'd23) ? 5'd0 : a_hr_q + 5'd1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (e_mode) state_d = SET_TH;
                    else if (snooze_go) state_d = LOAD_A;
            SET_TH: if (e_mode) state_d = SET_TM;
            SET_TM: if (e_mode) state_d = LOAD_T;
            LOAD_T: state_d = SET_AH;
            SET_AH: if (e_mode) state_d = SET_AM;
            SET_AM: if (e_mode) state_d = LOAD_A;
            LOAD_A: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edit registers, snooze counter, enable and stop strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q     <= '0;
            t_hr_q    <= '0;
            t_min_q   <= '0;
            a_hr_q    <= '0;
            a_min_q   <= '0;
            snz_cnt_q <= '0;
            stop_q    <= 1'b0;
            al_on_q   <= 1'b0;
        end else begin
            btn_q  <= btn_now;
            stop_q <= e_stop || snooze_ok;

            if (inc_en) begin
                case (state_q)
                    SET_TH: t_hr_q  <= (t_hr_q  == 5'd23) ? 5'd0 : t_hr_q  + 5'd1;
                    SET_TM: t_min_q <= (t_min_q == 6'd59) ? 6'd0 : t_min_q + 6'd1;
                    SET_AH: a_hr_q  <= (a_hr_q  == 5'd23) ? 5'd0 : a_hr_q  + 5'd1;
                    SET_AM: a_min_q <= (a_min_q == 6'd59) ? 6'd0 : a_min_q + 6'd1;
                    default: ;
                endcase
            end

            if (snooze_go) begin
                a_hr_q  <= snz_hr;
                a_min_q <= snz_min;
            end

            if (e_stop || snooze_stop || (state_q == SET_AM && e_mode))
                snz_cnt_q <= '0;
            else if (snooze_go)
                snz_cnt_q <= snz_cnt_q + 3'd1;

            if (state_q == SET_AM && e_mode)
                al_on_q <= 1'b1;
            else if (state_q == IDLE && e_al_en)
                al_on_q <= ~al_on_q;
        end
    end

    // Output decode
    logic       show_time;
    logic [4:0] disp_hr;
    logic [5:0] disp_min;
    always_comb begin
        show_time = (state_q == SET_TH) || (state_q == SET_TM) || (state_q == LOAD_T);
        disp_hr   = show_time ? t_hr_q  : a_hr_q;
        disp_min  = show_time ? t_min_q : a_min_q;

        if (disp_hr >= 5'd20) begin
            H_in1 = 2'd2;
            H_in0 = 4'(disp_hr - 5'd20);
        end else if (disp_hr >= 5'd10) begin
            H_in1 = 2'd1;
            H_in0 = 4'(disp_hr - 5'd10);
        end else begin
            H_in1 = 2'd0;
            H_in0 = 4'(disp_hr);
        end
        M_in1 = 4'(disp_min / 6'd10);
        M_in0 = 4'(disp_min % 6'd10);

        LD_time  = (state_q == LOAD_T);
        LD_alarm = (state_q == LOAD_A);
        STOP_al  = stop_q;
        AL_ON    = al_on_q;
        mode     = state_q;
    end

endmodule

// File: tb/tb_alarm_set_ctrl.sv
module tb_alarm_set_ctrl;

    localparam int SN = 5;
    localparam int MX = 3;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MODE = 5'b10000;
    localparam logic [4:0] B_INC  = 5'b01000;
    localparam logic [4:0] B_SNZ  = 5'b00100;
    localparam logic [4:0] B_STOP = 5'b00010;
    localparam logic [4:0] B_EN   = 5'b00001;

    logic       clk = 1'b0;
    logic       reset, btn_mode, btn_inc, btn_snooze, btn_stop, btn_al_en, Alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, AL_ON;
    logic [2:0] mode;

    alarm_set_ctrl #(.SNOOZE_MIN(SN), .MAX_SNOOZE(MX)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
        .btn_stop(btn_stop), .btn_al_en(btn_al_en), .Alarm(Alarm),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
        .AL_ON(AL_ON), .mode(mode)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: clock settings kept as plain hours/minutes integers,
    // snooze computed as minutes-of-day arithmetic.
    int         m_st, m_th, m_tm, m_ah, m_am, m_al, m_cnt, m_stop;
    logic [4:0] m_prev;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst, input logic [4:0] b, input bit al);
        bit em, ei, es, et, ee;
        int nx, tot;
        if (rst) begin
            m_st = 0; m_th = 0; m_tm = 0; m_ah = 0; m_am = 0;
            m_al = 0; m_cnt = 0; m_stop = 0; m_prev = '0;
            return;
        end
        em = b[4] && !m_prev[4];
        ei = b[3] && !m_prev[3];
        es = b[2] && !m_prev[2];
        et = b[1] && !m_prev[1];
        ee = b[0] && !m_prev[0];
        m_prev = b;
        m_stop = 0;
        nx = m_st;
        if (et) begin m_stop = 1; m_cnt = 0; end
        case (m_st)
            0: begin
                if (em) nx = 1;
                else if (es && al && !et) begin
                    m_stop = 1;
                    if (m_cnt < MX) begin
                        tot  = (m_ah * 60 + m_am + SN) % 1440;
                        m_ah = tot / 60;
                        m_am = tot % 60;
                        m_cnt++;
                        nx = 6;
                    end else m_cnt = 0;
                end
                if (ee) m_al = !m_al;
            end
            1: if (em) nx = 2; else if (ei) m_th = (m_th + 1) % 24;
            2: if (em) nx = 3; else if (ei) m_tm = (m_tm + 1) % 60;
            3: nx = 4;
            4: if (em) nx = 5; else if (ei) m_ah = (m_ah + 1) % 24;
            5: if (em) begin nx = 6; m_al = 1; m_cnt = 0; end
               else if (ei) m_am = (m_am + 1) % 60;
            default: nx = 0;
        endcase
        m_st = nx;
    endtask

    task automatic check_model();
        int dh, dm;
        bit st_time;
        st_time = (m_st >= 1 && m_st <= 3);
        dh = st_time ? m_th : m_ah;
        dm = st_time ? m_tm : m_am;
        chk("mode",     mode,     m_st);
        chk("H_in1",    H_in1,    dh / 10);
        chk("H_in0",    H_in0,    dh % 10);
        chk("M_in1",    M_in1,    dm / 10);
        chk("M_in0",    M_in0,    dm % 10);
        chk("LD_time",  LD_time,  (m_st == 3) ? 1 : 0);
        chk("LD_alarm", LD_alarm, (m_st == 6) ? 1 : 0);
        chk("STOP_al",  STOP_al,  m_stop);
        chk("AL_ON",    AL_ON,    m_al);
    endtask

    // Called at a negedge; applies inputs over one rising edge and checks.
    task automatic step(input bit rst, input logic [4:0] b);
        reset = rst;
        {btn_mode, btn_inc, btn_snooze, btn_stop, btn_al_en} = b;
        @(posedge clk);
        model_update(rst, b, Alarm);
        @(negedge clk);
        check_model();
    endtask

    task automatic press(input logic [4:0] b);
        step(1'b0, b);
        step(1'b0, B_NONE);
    endtask

    task automatic press_n(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic chk_disp(input string tag, input int h1, input int h0, input int m1, input int m0);
        chk({tag, "_H1"}, H_in1, h1);
        chk({tag, "_H0"}, H_in0, h0);
        chk({tag, "_M1"}, M_in1, m1);
        chk({tag, "_M0"}, M_in0, m0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Alarm = 1'b0;
        {btn_mode, btn_inc, btn_snooze, btn_stop, btn_al_en} = B_NONE;
        @(negedge clk);
        step(1'b1, B_NONE);
        step(1'b1, B_NONE);
        chk("rst_mode", mode, 0);
        chk("rst_AL_ON", AL_ON, 0);
        chk_disp("rst", 0, 0, 0, 0);

        // Set time 10:02
        press(B_MODE);
        chk("set_th_mode", mode, 1);
        press_n(B_INC, 10);
        press(B_MODE);
        press_n(B_INC, 2);
        step(1'b0, B_MODE);
        chk("ld_time", LD_time, 1);
        chk("ld_time_mode", mode, 3);
        chk_disp("ld_time", 1, 0, 0, 2);
        step(1'b0, B_NONE);
        chk("after_ldt_mode", mode, 4);
        chk("after_ldt_LD", LD_time, 0);

        // Alarm hour wraps after 24 increments, minute after 61 -> 01
        press_n(B_INC, 24);
        chk_disp("hr_wrap", 0, 0, 0, 0);
        press(B_MODE);
        press_n(B_INC, 61);
        step(1'b0, B_MODE);
        chk("ld_alarm", LD_alarm, 1);
        chk("ld_alarm_AL_ON", AL_ON, 1);
        chk_disp("ld_alarm", 0, 0, 0, 1);
        step(1'b0, B_NONE);
        chk("idle_mode", mode, 0);
        chk("idle_LD_alarm", LD_alarm, 0);

        // Alarm 23:58 then snooze -> 00:03
        press_n(B_MODE, 3);
        chk("to_set_ah", mode, 4);
        press_n(B_INC, 23);
        press(B_MODE);
        press_n(B_INC, 57);
        press(B_MODE);
        chk_disp("al_2358", 2, 3, 5, 8);
        Alarm = 1'b1;
        step(1'b0, B_SNZ);
        chk("snz1_stop", STOP_al, 1);
        chk("snz1_ld", LD_alarm, 1);
        chk_disp("snz1", 0, 0, 0, 3);
        step(1'b0, B_NONE);
        chk("snz1_stop_end", STOP_al, 0);
        chk("snz1_ld_end", LD_alarm, 0);

        // Exhaust snoozes; the fourth acts as stop and clears the counter
        press_n(B_SNZ, 2);
        step(1'b0, B_SNZ);
        chk("snz4_stop", STOP_al, 1);
        chk("snz4_no_ld", LD_alarm, 0);
        chk("snz4_mode", mode, 0);
        chk_disp("snz4", 0, 0, 1, 3);
        step(1'b0, B_NONE);
        step(1'b0, B_SNZ);
        chk("snz5_ld", LD_alarm, 1);
        chk_disp("snz5", 0, 0, 1, 8);
        step(1'b0, B_NONE);
        Alarm = 1'b0;

        // Stop in an edit state keeps state; al_en ignored outside IDLE
        press(B_MODE);
        step(1'b0, B_STOP);
        chk("stop_edit", STOP_al, 1);
        chk("stop_edit_mode", mode, 1);
        step(1'b0, B_EN);
        chk("al_en_ignored", AL_ON, 1);

        // Held mode: one advance only
        for (int i = 0; i < 20; i++) step(1'b0, B_MODE);
        chk("held_mode", mode, 2);
        step(1'b0, B_NONE);

        // Reset mid-edit overrides a concurrent mode edge
        step(1'b1, B_MODE);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_AL_ON", AL_ON, 0);
        chk("mid_rst_stop", STOP_al, 0);
        chk_disp("mid_rst", 0, 0, 0, 0);
        step(1'b0, B_NONE);
        chk("post_rst_ldt", LD_time, 0);
        chk("post_rst_mode", mode, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] b;
            bit rst;
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 2) == 0);
            Alarm = 1'($urandom_range(0, 1));
            step(rst, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
